trap_halt_ctrl: RTL and testbench

Simulation-halt responder for the RV64 core. It accepts the trap request that decode raises on `ebreak`, stalls fetch, and waits for the pipeline to drain. It then reads `a0` (x10) through a handshaked register-file read port, latches the exit code, and holds a terminal halted state with good/bad verdicts and frozen cycle/instret counters for the testbench to sample.

---
 rtl/trap_halt_ctrl_if.sv | 30 +++
 rtl/trap_halt_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_trap_halt_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_halt_ctrl_if.sv
// trap_halt_ctrl_if
// Register-file read port used by the halt controller to fetch a0 (x10).
//   rd_req  : read request, held until rd_ack
//   rd_addr : register index to read
//   rd_ack  : read complete, rd_data valid in the same cycle
//   rd_data : register value
// The master modport belongs to the halt controller; the register file
// (or a testbench model of it) uses the slave modport.
interface trap_halt_ctrl_if #(
  parameter int XLEN = 64
);
  logic            rd_req;
  logic [4:0]      rd_addr;
  logic            rd_ack;
  logic [XLEN-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );
endinterface

// File: rtl/trap_halt_ctrl.sv
// trap_halt_ctrl
// Simulation-halt responder for the RV64 core. On an ebreak trap request it
// stalls fetch, waits for the pipeline to drain (bounded by DRAIN_TIMEOUT),
// reads a0 through the register-file read port, and then parks in a terminal
// HALT state presenting the exit code, the trap PC, a good/bad verdict and
// frozen cycle/instret counters.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   trap_req, trap_pc        : ebreak decoded this cycle and its PC
//   pipe_empty               : no older instruction in flight
//   commit                   : one instruction retired this cycle
//   stall_fetch              : block fetch/issue
//   rf                       : register-file read port (master side)
//   halted                   : terminal state reached
//   hit_good, hit_bad        : verdict, valid while halted
//   timeout                  : halt was forced by drain timeout
//   exit_code, halt_pc       : latched a0 and latched trap PC
//   cycle_cnt, instret_cnt   : cycle / retired-instruction counters
module trap_halt_ctrl #(
  parameter int XLEN          = 64,
  parameter int CNT_W         = 64,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              pipe_empty,
  input  logic              commit,
  output logic              stall_fetch,
  trap_halt_ctrl_if.master  rf,
  output logic              halted,
  output logic              hit_good,
  output logic              hit_bad,
  output logic              timeout,
  output logic [XLEN-1:0]   exit_code,
  output logic [XLEN-1:0]   halt_pc,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  localparam int DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    READ_A0 = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t           state_r,     state_nxt_s;
  logic [DCW-1:0]   drain_cnt_r, drain_cnt_nxt_s;
  logic [XLEN-1:0]  halt_pc_r,   halt_pc_nxt_s;
  logic [XLEN-1:0]  exit_code_r, exit_code_nxt_s;
  logic             timeout_r,   timeout_nxt_s;
  logic             stall_r,     stall_nxt_s;
  logic             req_r,       req_nxt_s;
  logic             halted_r,    halted_nxt_s;
  logic             good_r,      good_nxt_s;
  logic             bad_r,       bad_nxt_s;
  logic [CNT_W-1:0] cycle_r;
  logic [CNT_W-1:0] instret_r;

  // Next-state and next-output decode; outputs are computed from the next
  // state so that the registered outputs line up with the state they describe.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    halt_pc_nxt_s   = halt_pc_r;
    exit_code_nxt_s = exit_code_r;
    timeout_nxt_s   = timeout_r;

    case (state_r)
      IDLE: begin
        if (trap_req) begin
          state_nxt_s     = DRAIN;
          halt_pc_nxt_s   = trap_pc;
          drain_cnt_nxt_s = {DCW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        // An empty pipe takes priority over a timeout landing in the same cycle.
        if (pipe_empty) begin
          state_nxt_s = READ_A0;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s     = HALT;
          timeout_nxt_s   = 1'b1;
          exit_code_nxt_s = {XLEN{1'b1}};
        end else begin
          drain_cnt_nxt_s = drain_cnt_r + DCW'(1);
        end
      end
      READ_A0: begin
        if (rf.rd_ack) begin
          state_nxt_s     = HALT;
          exit_code_nxt_s = rf.rd_data;
        end else begin
          state_nxt_s = READ_A0;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    stall_nxt_s  = (state_nxt_s != IDLE);
    req_nxt_s    = (state_nxt_s == READ_A0);
    halted_nxt_s = (state_nxt_s == HALT);
    if (halted_nxt_s) begin
      good_nxt_s = (exit_code_nxt_s == {XLEN{1'b0}}) && !timeout_nxt_s;
      bad_nxt_s  = !good_nxt_s;
    end else begin
      good_nxt_s = 1'b0;
      bad_nxt_s  = 1'b0;
    end
  end

  // State, latched data and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      drain_cnt_r <= {DCW{1'b0}};
      halt_pc_r   <= {XLEN{1'b0}};
      exit_code_r <= {XLEN{1'b0}};
      timeout_r   <= 1'b0;
      stall_r     <= 1'b0;
      req_r       <= 1'b0;
      halted_r    <= 1'b0;
      good_r      <= 1'b0;
      bad_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      halt_pc_r   <= halt_pc_nxt_s;
      exit_code_r <= exit_code_nxt_s;
      timeout_r   <= timeout_nxt_s;
      stall_r     <= stall_nxt_s;
      req_r       <= req_nxt_s;
      halted_r    <= halted_nxt_s;
      good_r      <= good_nxt_s;
      bad_r       <= bad_nxt_s;
    end
  end

  // Cycle and instret counters; they run in every state except HALT, so a
  // commit in the cycle that enters HALT is still counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_r   <= {CNT_W{1'b0}};
      instret_r <= {CNT_W{1'b0}};
    end else if (state_r != HALT) begin
      cycle_r <= cycle_r + CNT_W'(1);
      if (commit) begin
        instret_r <= instret_r + CNT_W'(1);
      end else begin
        instret_r <= instret_r;
      end
    end else begin
      cycle_r   <= cycle_r;
      instret_r <= instret_r;
    end
  end

  assign stall_fetch = stall_r;
  assign rf.rd_req   = req_r;
  assign rf.rd_addr  = 5'd10;
  assign halted      = halted_r;
  assign hit_good    = good_r;
  assign hit_bad     = bad_r;
  assign timeout     = timeout_r;
  assign exit_code   = exit_code_r;
  assign halt_pc     = halt_pc_r;
  assign cycle_cnt   = cycle_r;
  assign instret_cnt = instret_r;

endmodule

// File: tb/tb_trap_halt_ctrl.sv
// tb_trap_halt_ctrl
// Scoreboard bench for trap_halt_ctrl. Each trap issued pushes the expected
// halt record (verdict, exit code, PC, counters, halt cycle, read-request
// cycles) into a queue; a monitor pops and compares on every rising edge of
// halted. A register-file model answers reads after a programmable number
// of request cycles.
module tb_trap_halt_ctrl;

  logic        clock;
  logic        reset_n;
  logic        trap_req;
  logic [63:0] trap_pc;
  logic        pipe_empty;
  logic        commit;
  logic        stall_fetch;
  logic        halted;
  logic        hit_good;
  logic        hit_bad;
  logic        timeout;
  logic [63:0] exit_code;
  logic [63:0] halt_pc;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  trap_halt_ctrl_if #(.XLEN(64)) rf_if ();

  trap_halt_ctrl #(
    .XLEN(64),
    .CNT_W(64),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .pipe_empty  (pipe_empty),
    .commit      (commit),
    .stall_fetch (stall_fetch),
    .rf          (rf_if),
    .halted      (halted),
    .hit_good    (hit_good),
    .hit_bad     (hit_bad),
    .timeout     (timeout),
    .exit_code   (exit_code),
    .halt_pc     (halt_pc),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  typedef struct {
    logic [63:0] exit_code;
    logic [63:0] halt_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic        good;
    logic        bad;
    logic        to;
    int          cyc;
    int          reqs;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int tb_cyc;
  int ack_lat;
  int req_run;
  int req_total;
  logic force_ack;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-side cycle index: 0 in the first cycle after reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Register-file model: ack in the ack_lat-th consecutive request cycle.
  initial begin
    rf_if.rd_ack  = 1'b0;
    rf_if.rd_data = 64'd0;
    req_run   = 0;
    req_total = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        req_run      = 0;
        req_total    = 0;
        rf_if.rd_ack = 1'b0;
      end else begin
        #2;
        if (rf_if.rd_req) begin
          req_run++;
          req_total++;
        end else begin
          req_run = 0;
        end
        rf_if.rd_ack = force_ack || (rf_if.rd_req && (req_run == ack_lat));
      end
    end
  end

  // Monitor: compare the halt record whenever halted rises.
  initial begin
    logic halted_q;
    exp_t e;
    halted_q = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        halted_q = 1'b0;
      end else begin
        if (halted && !halted_q) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_halt", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("halt_cycle",  64'(tb_cyc),    64'(e.cyc));
            chk("exit_code",   exit_code,      e.exit_code);
            chk("halt_pc",     halt_pc,        e.halt_pc);
            chk("hit_good",    64'(hit_good),  64'(e.good));
            chk("hit_bad",     64'(hit_bad),   64'(e.bad));
            chk("timeout",     64'(timeout),   64'(e.to));
            chk("cycle_cnt",   cycle_cnt,      e.cycle_cnt);
            chk("instret_cnt", instret_cnt,    e.instret_cnt);
            chk("req_cycles",  64'(req_total), 64'(e.reqs));
          end
        end
        halted_q = halted;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_stall"},   64'(stall_fetch),   64'd0);
    chk({tag, "_rd_req"},  64'(rf_if.rd_req),  64'd0);
    chk({tag, "_rd_addr"}, 64'(rf_if.rd_addr), 64'd10);
    chk({tag, "_halted"},  64'(halted),        64'd0);
    chk({tag, "_good"},    64'(hit_good),      64'd0);
    chk({tag, "_bad"},     64'(hit_bad),       64'd0);
    chk({tag, "_timeout"}, 64'(timeout),       64'd0);
    chk({tag, "_exit"},    exit_code,          64'd0);
    chk({tag, "_pc"},      halt_pc,            64'd0);
    chk({tag, "_cycle"},   cycle_cnt,          64'd0);
    chk({tag, "_instret"}, instret_cnt,        64'd0);
  endtask

  // Asserts reset now (asynchronously), checks outputs, releases after an edge.
  task automatic do_reset(input string tag);
    reset_n    = 1'b0;
    trap_req   = 1'b0;
    commit     = 1'b0;
    pipe_empty = 1'b0;
    force_ack  = 1'b0;
    #1;
    check_reset_state(tag);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
    chk("halt_reached", 64'(halted), 64'd1);
  endtask

  task automatic push_exp(input logic [63:0] ec, input logic [63:0] pc, input int cyc,
                          input logic [63:0] inst, input logic good, input logic to,
                          input int reqs);
    exp_t e;
    e.exit_code   = ec;
    e.halt_pc     = pc;
    e.cycle_cnt   = 64'(cyc);
    e.instret_cnt = inst;
    e.good        = good;
    e.bad         = !good;
    e.to          = to;
    e.cyc         = cyc;
    e.reqs        = reqs;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b1;
    trap_req   = 1'b0;
    trap_pc    = 64'd0;
    pipe_empty = 1'b0;
    commit     = 1'b0;
    force_ack  = 1'b0;
    ack_lat    = 1;
    #3;

    // Good trap: trap at cycle 10, immediate drain and ack -> halted at 13.
    do_reset("rst1");
    repeat (10) step();
    chk("t1_stall_pre", 64'(stall_fetch), 64'd0);
    trap_req = 1'b1; trap_pc = 64'h8000_0040; pipe_empty = 1'b1;
    rf_if.rd_data = 64'd0; ack_lat = 1;
    push_exp(64'd0, 64'h8000_0040, 13, 64'd0, 1'b1, 1'b0, 1);
    step();
    trap_req = 1'b0;
    chk("t1_stall_post", 64'(stall_fetch), 64'd1);
    chk("t1_req_drain", 64'(rf_if.rd_req), 64'd0);
    step();
    chk("t1_req_read", 64'(rf_if.rd_req), 64'd1);
    wait_halt(5);
    step();
    chk("t1_req_drop", 64'(rf_if.rd_req), 64'd0);
    chk("t1_stall_halt", 64'(stall_fetch), 64'd1);
    commit = 1'b1;
    repeat (3) step();
    commit = 1'b0;
    chk("t1_cycle_frozen", cycle_cnt, 64'd13);
    chk("t1_instret_frozen", instret_cnt, 64'd0);

    // Slow register file: ack in 4th request cycle, a0=0x2A -> bad verdict.
    do_reset("rst2");
    repeat (2) step();
    trap_req = 1'b1; trap_pc = 64'h8000_0100; pipe_empty = 1'b1;
    rf_if.rd_data = 64'h2A; ack_lat = 4;
    push_exp(64'h2A, 64'h8000_0100, 8, 64'd0, 1'b0, 1'b0, 4);
    step();
    trap_req = 1'b0;
    wait_halt(10);
    step();

    // Drain wait with commits, an ignored second trap, and a commit in the
    // cycle that enters HALT.
    do_reset("rst3");
    repeat (3) step();
    rf_if.rd_data = 64'd0; ack_lat = 1;
    push_exp(64'd0, 64'h8000_0200, 10, 64'd4, 1'b1, 1'b0, 1);
    for (int c = 3; c <= 9; c++) begin
      pipe_empty = (c >= 8);
      commit     = (c == 4 || c == 5 || c == 7 || c == 9);
      trap_req   = (c == 3 || c == 5);
      trap_pc    = (c == 3) ? 64'h8000_0200 : 64'h1234;
      if (c == 8) chk("t3_req_before", 64'(rf_if.rd_req), 64'd0);
      if (c == 9) chk("t3_req_entry", 64'(rf_if.rd_req), 64'd1);
      step();
    end
    trap_req = 1'b0; commit = 1'b0;
    wait_halt(5);
    commit = 1'b1;
    repeat (3) step();
    commit = 1'b0;
    chk("t3_instret_frozen", instret_cnt, 64'd4);
    chk("t3_pc_kept", halt_pc, 64'h8000_0200);

    // Drain timeout: pipe never empties -> forced halt 17 cycles after trap.
    do_reset("rst4");
    step();
    trap_req = 1'b1; trap_pc = 64'h8000_0300; pipe_empty = 1'b0;
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0300, 18, 64'd0, 1'b0, 1'b1, 0);
    step();
    trap_req = 1'b0;
    wait_halt(30);
    step();

    // Reset mid-READ_A0, ignored late ack, then a normal sequence.
    do_reset("rst5");
    step();
    trap_req = 1'b1; trap_pc = 64'h8000_0380; pipe_empty = 1'b1; ack_lat = 100;
    step();
    trap_req = 1'b0;
    repeat (2) step();
    chk("t5_in_read", 64'(rf_if.rd_req), 64'd1);
    do_reset("mid_read");
    force_ack = 1'b1;
    repeat (2) step();
    force_ack = 1'b0;
    chk("t5_late_ack_stall", 64'(stall_fetch), 64'd0);
    chk("t5_late_ack_halted", 64'(halted), 64'd0);
    step();
    trap_req = 1'b1; trap_pc = 64'h8000_0400; pipe_empty = 1'b1; ack_lat = 1;
    rf_if.rd_data = 64'd0;
    push_exp(64'd0, 64'h8000_0400, 6, 64'd0, 1'b1, 1'b0, 1);
    step();
    trap_req = 1'b0;
    wait_halt(5);
    step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
